// File: rtl/set_assoc_cache.sv
// N-way set-associative write-through, write-allocate cache with pipelined block fill,
// tree pseudo-LRU replacement, flush and saturating hit/miss counters.
module set_assoc_cache #(
  parameter int WAYS  = 2,
  parameter int SETS  = 64,
  parameter int WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wen,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        flush,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [15:0] mem_rdata,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  // state  | meaning
  // IDLE   | combinational lookup; hits complete, misses start a fill
  // FILL   | issue WORDS reads, collect responses into the victim way
  // REPLAY | one-cycle re-lookup that completes the stalled request
  typedef enum logic [1:0] {IDLE, FILL, REPLAY} state_t;

  localparam int WB  = $clog2(WORDS);
  localparam int OFF = WB + 1;
  localparam int IDX = $clog2(SETS);
  localparam int TAG = 16 - OFF - IDX;
  localparam int LV  = $clog2(WAYS);
  localparam int WW  = (WAYS > 1) ? LV : 1;
  localparam int PW  = (WAYS > 1) ? WAYS - 1 : 1;

  state_t state_q, state_d;

  logic [TAG-1:0]             tag_mem  [WAYS][SETS];
  logic [15:0]                data_mem [WAYS][SETS][WORDS];
  logic [SETS-1:0][WAYS-1:0]  valid_q;
  logic [SETS-1:0][PW-1:0]    plru_q;

  logic [WB:0]   icnt_q;
  logic [WB-1:0] rcnt_q;
  logic [WW-1:0] victim_q;

  logic [TAG-1:0]  tag_in;
  logic [IDX-1:0]  idx;
  logic [WB-1:0]   word;
  logic [WAYS-1:0] valid_set;
  logic [PW-1:0]   plru_set;
  logic [WAYS-1:0] hit_vec;
  logic            hit;
  logic [WW-1:0]   hit_way;
  logic [WW-1:0]   victim_sel;
  logic [15:0]     rd_word;

  logic            dwe;
  logic [WW-1:0]   dway;
  logic [WB-1:0]   dword;
  logic [15:0]     ddata;
  logic            touch, hit_inc, miss_inc, start_fill, fill_done, do_flush;

  logic unused_addr_bit;
  assign unused_addr_bit = req_addr[0];

  assign tag_in    = req_addr[15 -: TAG];
  assign idx       = req_addr[OFF+IDX-1:OFF];
  assign word      = req_addr[OFF-1:1];
  assign valid_set = valid_q[idx];
  assign plru_set  = plru_q[idx];
  assign rd_word   = data_mem[hit_way][idx][word];

  for (genvar g = 0; g < WAYS; g++) begin : g_cmp
    assign hit_vec[g] = valid_set[g] && (tag_mem[g][idx] == tag_in);
  end

  // Walks the tree setting every bit on the path to point away from way w.
  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] cur, input logic [WW-1:0] w);
    logic [PW-1:0] nxt;
    logic [WW-1:0] sh;
    int node;
    nxt  = cur;
    node = 0;
    for (int l = 0; l < LV; l++) begin
      sh   = w >> (LV - 1 - l);
      nxt  = (nxt & ~(PW'(1) << node)) | (PW'(~sh[0]) << node);
      node = 2 * node + 1 + int'(sh[0]);
    end
    return nxt;
  endfunction

  always_comb begin
    logic [WAYS-1:0] hb, vb;
    logic [PW-1:0]   pb;
    logic            inv_found;
    logic [WW-1:0]   vic_inv;
    int              node;
    hit       = |hit_vec;
    hit_way   = '0;
    inv_found = 1'b0;
    vic_inv   = '0;
    node      = 0;
    for (int w = 0; w < WAYS; w++) begin
      hb = hit_vec >> w;
      if (hb[0]) hit_way = WW'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      vb = valid_set >> w;
      if (!vb[0]) begin
        inv_found = 1'b1;
        vic_inv   = WW'(w);
      end
    end
    for (int l = 0; l < LV; l++) begin
      pb   = plru_set >> node;
      node = 2 * node + 1 + int'(pb[0]);
    end
    victim_sel = inv_found ? vic_inv : WW'(node - (WAYS - 1));
  end

  always_comb begin
    state_d    = state_q;
    rsp_valid  = 1'b0;
    stall      = 1'b0;
    mem_req    = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    dwe        = 1'b0;
    dway       = hit_way;
    dword      = word;
    ddata      = req_wdata;
    touch      = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    start_fill = 1'b0;
    fill_done  = 1'b0;
    do_flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          do_flush = 1'b1;
          stall    = req_valid;
        end else if (req_valid) begin
          if (hit) begin
            rsp_valid = 1'b1;
            touch     = 1'b1;
            hit_inc   = 1'b1;
            if (req_wen) begin
              dwe       = 1'b1;
              mem_req   = 1'b1;
              mem_wen   = 1'b1;
              mem_addr  = req_addr;
              mem_wdata = req_wdata;
            end
          end else begin
            stall      = 1'b1;
            miss_inc   = 1'b1;
            start_fill = 1'b1;
            state_d    = FILL;
          end
        end
      end
      FILL: begin
        stall = 1'b1;
        if (!icnt_q[WB]) begin
          mem_req  = 1'b1;
          mem_addr = {tag_in, idx, icnt_q[WB-1:0], 1'b0};
        end
        if (mem_rsp_valid) begin
          dwe   = 1'b1;
          dway  = victim_q;
          dword = rcnt_q;
          ddata = mem_rdata;
          if (&rcnt_q) begin
            fill_done = 1'b1;
            state_d   = REPLAY;
          end
        end
      end
      REPLAY: begin
        state_d = IDLE;
        if (req_valid && hit) begin
          rsp_valid = 1'b1;
          touch     = 1'b1;
          if (req_wen) begin
            dwe       = 1'b1;
            mem_req   = 1'b1;
            mem_wen   = 1'b1;
            mem_addr  = req_addr;
            mem_wdata = req_wdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_rdata = rsp_valid ? rd_word : 16'h0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      icnt_q     <= '0;
      rcnt_q     <= '0;
      victim_q   <= '0;
      valid_q    <= '0;
      plru_q     <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state_q <= state_d;
      if (start_fill) begin
        icnt_q   <= '0;
        rcnt_q   <= '0;
        victim_q <= victim_sel;
      end else if (state_q == FILL) begin
        if (!icnt_q[WB]) icnt_q <= icnt_q + (WB+1)'(1);
        if (mem_rsp_valid) rcnt_q <= rcnt_q + WB'(1);
      end
      if (do_flush) begin
        valid_q <= '0;
        plru_q  <= '0;
      end else begin
        if (fill_done) valid_q[idx] <= valid_set | (WAYS'(1) << victim_q);
        if (touch) plru_q[idx] <= plru_touch(plru_set, hit_way);
      end
      if (hit_inc && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (miss_inc && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (dwe) data_mem[dway][idx][dword] <= ddata;
    if (fill_done) tag_mem[victim_q][idx] <= tag_in;
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache (4-way) with a 3-cycle pipelined memory model.
module tb_set_assoc_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_wen = 1'b0, flush = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, stall, mem_req, mem_wen, mem_rsp_valid;
  logic [15:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata, hit_count, miss_count;

  int checks = 0;
  int failures = 0;

  set_assoc_cache #(.WAYS(4), .SETS(64), .WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .stall(stall),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Memory: untouched words hold a fixed pattern; stores override it.
  logic [15:0] wr_mem [logic [15:0]];
  logic [15:0] rd_q [$];

  function automatic logic [15:0] mem_init(input logic [15:0] a);
    return (a * 16'd7) ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    if (wr_mem.exists(a)) return wr_mem[a];
    return mem_init(a);
  endfunction

  logic [16:0] p0, p1, p2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0 <= '0;
      p1 <= '0;
      p2 <= '0;
    end else begin
      p0 <= {mem_req & ~mem_wen, mem_read({mem_addr[15:1], 1'b0})};
      p1 <= p0;
      p2 <= p1;
    end
  end
  assign mem_rsp_valid = p2[16];
  assign mem_rdata     = p2[15:0];

  always @(negedge clk) begin
    if (!rst && mem_req && mem_wen) wr_mem[{mem_addr[15:1], 1'b0}] = mem_wdata;
    if (!rst && mem_req && !mem_wen) rd_q.push_back(mem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_fill(input string name, input logic [15:0] a);
    logic [15:0] base;
    int n;
    base = a & 16'hFFF0;
    n = 0;
    for (int i = 0; i < rd_q.size(); i++)
      if (rd_q[i] == base + 16'(2 * i)) n++;
    check({name, "_fill_reads"}, rd_q.size(), 8);
    check({name, "_fill_addrs"}, n, 8);
  endtask

  // Holds the request until rsp_valid; cyc counts the stall cycles before it.
  task automatic access(input logic [15:0] a, input logic w, input logic [15:0] d, input int flush_at,
                        output logic [15:0] rd, output int cyc, output logic mr, output logic mw,
                        output logic [15:0] ma, output logic st);
    req_valid = 1'b1;
    req_wen   = w;
    req_addr  = a;
    req_wdata = d;
    cyc = 0;
    @(negedge clk);
    while (!rsp_valid && cyc < 60) begin
      cyc++;
      flush = (cyc == flush_at);
      @(negedge clk);
    end
    flush = 1'b0;
    rd = rsp_rdata;
    mr = mem_req;
    mw = mem_wen;
    ma = mem_addr;
    st = stall;
    if (cyc >= 60) begin
      checks++;
      failures++;
      $display("FAIL access_timeout: got no rsp_valid for addr %0h required rsp_valid", a);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wen   = 1'b0;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        wen;
    logic [15:0] wdata;
    logic        chk_rd;
    logic [15:0] exp_rd;
    int          exp_cyc;
    logic        exp_mreq;
    int          exp_hits;
    int          exp_miss;
  } vec_t;

  vec_t vecs [18];

  initial begin
    logic [15:0] rd, ma;
    int cyc, n;
    logic mr, mw, st;

    // addr fields: tag[15:10] set[9:4] word[3:1]; set 5 tags 0..4 at t*0x400+0x50
    vecs[0]  = '{16'h0412, 1'b0, 16'h0000, 1'b1, mem_init(16'h0412), 12, 1'b0, 0, 1};
    vecs[1]  = '{16'h0414, 1'b0, 16'h0000, 1'b1, mem_init(16'h0414), 0, 1'b0, 1, 1};
    vecs[2]  = '{16'h0416, 1'b1, 16'hBEEF, 1'b0, 16'h0000, 0, 1'b1, 2, 1};
    vecs[3]  = '{16'h0416, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 0, 1'b0, 3, 1};
    vecs[4]  = '{16'h0050, 1'b0, 16'h0000, 1'b1, mem_init(16'h0050), 12, 1'b0, 3, 2};
    vecs[5]  = '{16'h0450, 1'b0, 16'h0000, 1'b1, mem_init(16'h0450), 12, 1'b0, 3, 3};
    vecs[6]  = '{16'h0850, 1'b0, 16'h0000, 1'b1, mem_init(16'h0850), 12, 1'b0, 3, 4};
    vecs[7]  = '{16'h0C50, 1'b0, 16'h0000, 1'b1, mem_init(16'h0C50), 12, 1'b0, 3, 5};
    vecs[8]  = '{16'h0050, 1'b0, 16'h0000, 1'b1, mem_init(16'h0050), 0, 1'b0, 4, 5};
    vecs[9]  = '{16'h0850, 1'b0, 16'h0000, 1'b1, mem_init(16'h0850), 0, 1'b0, 5, 5};
    vecs[10] = '{16'h0450, 1'b0, 16'h0000, 1'b1, mem_init(16'h0450), 0, 1'b0, 6, 5};
    vecs[11] = '{16'h1050, 1'b0, 16'h0000, 1'b1, mem_init(16'h1050), 12, 1'b0, 6, 6};
    vecs[12] = '{16'h0050, 1'b0, 16'h0000, 1'b1, mem_init(16'h0050), 0, 1'b0, 7, 6};
    vecs[13] = '{16'h0450, 1'b0, 16'h0000, 1'b1, mem_init(16'h0450), 0, 1'b0, 8, 6};
    vecs[14] = '{16'h0850, 1'b0, 16'h0000, 1'b1, mem_init(16'h0850), 0, 1'b0, 9, 6};
    vecs[15] = '{16'h0C50, 1'b0, 16'h0000, 1'b1, mem_init(16'h0C50), 12, 1'b0, 9, 7};
    vecs[16] = '{16'h0812, 1'b1, 16'h1234, 1'b0, 16'h0000, 12, 1'b1, 9, 8};
    vecs[17] = '{16'h0812, 1'b0, 16'h0000, 1'b1, 16'h1234, 0, 1'b0, 10, 8};

    #1;
    check("rst_stall_idle", stall, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
    req_valid = 1'b1;
    req_addr  = 16'h0412;
    #1;
    check("rst_stall_follows_req", stall, 1);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      rd_q.delete();
      access(vecs[i].addr, vecs[i].wen, vecs[i].wdata, -1, rd, cyc, mr, mw, ma, st);
      check($sformatf("v%0d_stall_cycles", i), cyc, vecs[i].exp_cyc);
      check($sformatf("v%0d_stall_at_rsp", i), st, 0);
      check($sformatf("v%0d_mem_req", i), mr, vecs[i].exp_mreq);
      if (vecs[i].exp_mreq) begin
        check($sformatf("v%0d_mem_wen", i), mw, 1);
        check($sformatf("v%0d_mem_addr", i), ma, vecs[i].addr);
      end
      if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      if (vecs[i].exp_cyc != 0) check_fill($sformatf("v%0d", i), vecs[i].addr);
      check($sformatf("v%0d_hit_count", i), hit_count, vecs[i].exp_hits);
      check($sformatf("v%0d_miss_count", i), miss_count, vecs[i].exp_miss);
    end

    // Flush with a request in the same cycle: stalled, then looked up after the flush.
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 16'h0412;
    flush     = 1'b1;
    @(negedge clk);
    check("flush_same_cycle_stall", stall, 1);
    check("flush_same_cycle_rsp", rsp_valid, 0);
    check("flush_same_cycle_mem_req", mem_req, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    rd_q.delete();
    access(16'h0412, 1'b0, 16'h0000, -1, rd, cyc, mr, mw, ma, st);
    check("after_flush_refill_cycles", cyc, 12);
    check("after_flush_rdata", rd, mem_init(16'h0412));
    check_fill("after_flush", 16'h0412);
    check("after_flush_miss_count", miss_count, 9);
    check("after_flush_hit_count", hit_count, 10);

    // Flush pulsed in the middle of a fill is ignored.
    access(16'h0C12, 1'b0, 16'h0000, 5, rd, cyc, mr, mw, ma, st);
    check("fill_flush_cycles", cyc, 12);
    check("fill_flush_rdata", rd, mem_init(16'h0C12));
    access(16'h0412, 1'b0, 16'h0000, -1, rd, cyc, mr, mw, ma, st);
    check("fill_flush_old_line_hits", cyc, 0);
    check("fill_flush_old_line_rdata", rd, mem_init(16'h0412));
    access(16'h0C12, 1'b0, 16'h0000, -1, rd, cyc, mr, mw, ma, st);
    check("fill_flush_new_line_hits", cyc, 0);
    check("fill_flush_counts", {hit_count, miss_count}, {16'd12, 16'd10});

    // Reset partway through a fill.
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 16'h1012;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (mem_rsp_valid) n++;
    end
    check("midfill_words_seen", n, 4);
    rst = 1'b1;
    #1;
    check("midfill_rst_stall", stall, 1);
    check("midfill_rst_rsp_valid", rsp_valid, 0);
    check("midfill_rst_mem_req", mem_req, 0);
    check("midfill_rst_counts", {hit_count, miss_count}, 32'd0);
    req_valid = 1'b0;
    #1;
    check("midfill_rst_stall_noreq", stall, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rd_q.delete();
    access(16'h1012, 1'b0, 16'h0000, -1, rd, cyc, mr, mw, ma, st);
    check("post_rst_refill_cycles", cyc, 12);
    check("post_rst_rdata", rd, mem_init(16'h1012));
    check_fill("post_rst", 16'h1012);
    check("post_rst_miss_count", miss_count, 1);
    access(16'h0412, 1'b0, 16'h0000, -1, rd, cyc, mr, mw, ma, st);
    check("post_rst_old_line_misses", cyc, 12);
    check("post_rst_old_line_rdata", rd, mem_init(16'h0412));
    check("post_rst_final_counts", {hit_count, miss_count}, {16'd0, 16'd2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1);
  end

endmodule
